// File: rtl/vc_mem_port_arb_pkg.sv
// Shared types, message widths and sizing helpers for the 2:1 memory port arbiter.
// Message layouts follow the vc mem msg convention:
//   req  = {type[2:0], opaque, addr, len, data}
//   resp = {type[2:0], opaque, test[1:0], len, data}
// The arbiter never looks inside a message, so only the total widths matter here.
package vc_mem_port_arb_pkg;

   // Requester port identifier stored in the in-order ID FIFO.
   typedef logic [0:0] port_id_t;

   localparam port_id_t c_port0 = 1'b0;
   localparam port_id_t c_port1 = 1'b1;

   // Width of the byte-length field for a given data width.
   function automatic int f_len_nbits(input int data_nbits);
      return $clog2(data_nbits / 8);
   endfunction

   // Total request message width.
   function automatic int f_req_nbits(input int o, input int a, input int d);
      return 3 + o + a + f_len_nbits(d) + d;
   endfunction

   // Total response message width.
   function automatic int f_resp_nbits(input int o, input int d);
      return 3 + o + 2 + f_len_nbits(d) + d;
   endfunction

   // ID FIFO pointer width; a depth-2 FIFO still needs one pointer bit.
   function automatic int f_ptr_nbits(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   // Widths for the default 8/32/32 configuration.
   localparam int c_req_nbits  = f_req_nbits(8, 32, 32);
   localparam int c_resp_nbits = f_resp_nbits(8, 32);

endpackage

// File: rtl/vc_mem_port_arb_id_fifo.sv
// In-order FIFO of requester IDs. One entry is pushed for every request that
// reaches memory and popped for every response handed back, so the head always
// names the port that owns the next memory response.
// Depth must be a power of two (>= 2) so the pointers wrap naturally.
module vc_mem_port_arb_id_fifo
   import vc_mem_port_arb_pkg::*;
#(
   parameter int p_depth = 4
)(
   input  logic     clk,
   input  logic     reset,
   input  logic     i_push,
   input  port_id_t i_push_id,
   input  logic     i_pop,
   output port_id_t o_head,
   output logic     o_full,
   output logic     o_empty
);

   localparam int c_ptr_nbits = f_ptr_nbits(p_depth);
   localparam int c_cnt_nbits = $clog2(p_depth) + 1;

   port_id_t                 r_mem [p_depth];
   logic [c_ptr_nbits-1:0]   r_rd_ptr;
   logic [c_ptr_nbits-1:0]   r_wr_ptr;
   logic [c_cnt_nbits-1:0]   r_count;

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == c_cnt_nbits'(p_depth));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rd_ptr];

   // The arbiter never pushes while full or pops while empty; the guards only
   // keep the counters consistent if that ever changes.
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // Storage needs no reset: entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_push_id;
   end

   // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + c_ptr_nbits'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + c_ptr_nbits'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_cnt_nbits'(1);
            2'b01:   r_count <= r_count - c_cnt_nbits'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/vc_mem_port_arb_2to1.sv
// Two-requester arbiter in front of a single-ported val/rdy test memory.
// Requests are granted combinationally onto the memory port; the winner's ID is
// queued so in-order memory responses can be steered back to the right port.
// Build option: VC_MEM_PORT_ARB_FIXED_PRIO_EN selects fixed priority (port 0
// wins ties); without it ties alternate round-robin.
module vc_mem_port_arb_2to1
   import vc_mem_port_arb_pkg::*;
#(
   parameter  int p_opaque_nbits    = 8,
   parameter  int p_addr_nbits      = 32,
   parameter  int p_data_nbits      = 32,
   parameter  int p_max_outstanding = 4,
   localparam int c_rq_nbits        = f_req_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
   localparam int c_rs_nbits        = f_resp_nbits(p_opaque_nbits, p_data_nbits)
)(
   input  logic                  clk,
   input  logic                  reset,

   input  logic                  req0_val,
   output logic                  req0_rdy,
   input  logic [c_rq_nbits-1:0] req0_msg,

   input  logic                  req1_val,
   output logic                  req1_rdy,
   input  logic [c_rq_nbits-1:0] req1_msg,

   output logic                  resp0_val,
   input  logic                  resp0_rdy,
   output logic [c_rs_nbits-1:0] resp0_msg,

   output logic                  resp1_val,
   input  logic                  resp1_rdy,
   output logic [c_rs_nbits-1:0] resp1_msg,

   output logic                  memreq_val,
   input  logic                  memreq_rdy,
   output logic [c_rq_nbits-1:0] memreq_msg,

   input  logic                  memresp_val,
   output logic                  memresp_rdy,
   input  logic [c_rs_nbits-1:0] memresp_msg
);

   // Lock holds a grant that was presented but not yet accepted, so the
   // message on memreq_msg cannot change under a stalled memory.
   logic     r_lock;
   port_id_t r_lock_id;

   port_id_t w_grant;
   logic     w_full;
   logic     w_empty;
   port_id_t w_head;
   logic     w_req_fire;
   logic     w_resp_fire;

   //---------------------------------------------------------------------------
   // Request side
   //---------------------------------------------------------------------------

`ifdef VC_MEM_PORT_ARB_FIXED_PRIO_EN
   // Grant: locked port first, otherwise port 0 wins any tie.
   always_comb begin
      w_grant = c_port0;
      if (r_lock)
         w_grant = r_lock_id;
      else if (req0_val && req1_val)
         w_grant = c_port0;
      else if (req1_val)
         w_grant = c_port1;
   end
`else
   // Port that wins the next tie; flips to the loser after every accepted request.
   logic r_prio;

   // Grant: locked port first, otherwise the valid port, ties go to r_prio.
   always_comb begin
      w_grant = c_port0;
      if (r_lock)
         w_grant = r_lock_id;
      else if (req0_val && req1_val)
         w_grant = port_id_t'(r_prio);
      else if (req1_val)
         w_grant = c_port1;
   end

   // Round-robin pointer moves only on an accepted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_prio <= 1'b0;
      else if (w_req_fire)
         r_prio <= ~w_grant[0];
   end
`endif

   // With the ID FIFO full there is nowhere to record a new owner, so stall.
   assign memreq_val = (req0_val | req1_val) & ~w_full;
   assign memreq_msg = (w_grant == c_port1) ? req1_msg : req0_msg;
   assign req0_rdy   = (w_grant == c_port0) & memreq_rdy & ~w_full;
   assign req1_rdy   = (w_grant == c_port1) & memreq_rdy & ~w_full;
   assign w_req_fire = memreq_val & memreq_rdy;

   // Lock onto a presented-but-stalled grant; release once it is accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lock    <= 1'b0;
         r_lock_id <= c_port0;
      end else if (w_req_fire) begin
         r_lock    <= 1'b0;
      end else if (memreq_val) begin
         r_lock    <= 1'b1;
         r_lock_id <= w_grant;
      end
   end

   //---------------------------------------------------------------------------
   // Outstanding-request bookkeeping
   //---------------------------------------------------------------------------

   vc_mem_port_arb_id_fifo #(
      .p_depth   (p_max_outstanding)
   ) u_id_fifo (
      .clk       (clk),
      .reset     (reset),
      .i_push    (w_req_fire),
      .i_push_id (w_grant),
      .i_pop     (w_resp_fire),
      .o_head    (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   //---------------------------------------------------------------------------
   // Response side
   //---------------------------------------------------------------------------

   // The memory answers in request order, so the FIFO head owns memresp_msg.
   // A response with nothing outstanding is left unconsumed.
   assign resp0_val   = memresp_val & ~w_empty & (w_head == c_port0);
   assign resp1_val   = memresp_val & ~w_empty & (w_head == c_port1);
   assign resp0_msg   = memresp_msg;
   assign resp1_msg   = memresp_msg;
   assign memresp_rdy = ~w_empty & ((w_head == c_port1) ? resp1_rdy : resp0_rdy);
   assign w_resp_fire = memresp_val & memresp_rdy;

`ifndef SYNTHESIS
   // Report a memory response that no request is waiting for.
   always_ff @(posedge clk) begin
      if (!reset && memresp_val && w_empty)
         $display("vc_mem_port_arb_2to1: ERROR memresp_val with no outstanding request at %0t", $time);
   end
`endif

endmodule

// File: tb/tb_vc_mem_port_arb_2to1.sv
// Randomised and directed bench for vc_mem_port_arb_2to1. A behavioural model
// (queue of outstanding owners, held grant, tie-break bit) predicts every
// output each cycle; a bench-side memory with random latency answers requests.
module tb_vc_mem_port_arb_2to1;
   import vc_mem_port_arb_pkg::*;

`ifdef VC_MEM_PORT_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [2:0]  typ;
      logic [7:0]  opq;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } req_t;
   typedef struct packed {
      logic [2:0]  typ;
      logic [7:0]  opq;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } resp_t;

   logic  clk = 1'b0;
   logic  reset = 1'b1;
   logic  req0_val = 0, req0_rdy, req1_val = 0, req1_rdy;
   req_t  req0_msg = '0, req1_msg = '0, memreq_msg;
   logic  resp0_val, resp0_rdy = 0, resp1_val, resp1_rdy = 0;
   resp_t resp0_msg, resp1_msg, memresp_msg = '0;
   logic  memreq_val, memreq_rdy = 0, memresp_val = 0, memresp_rdy;

   vc_mem_port_arb_2to1 dut (
      .clk(clk), .reset(reset),
      .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg),
      .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg),
      .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg),
      .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;

   // Bench state: sources, model, memory, scoreboard, logs.
   req_t  src_q [2][$];
   bit    pres [2];
   int    seq [2];
   int    mdl_q [$];
   int    held;
   bit    rr;
   resp_t mem_q [$];
   int    mem_t [$];
   int    last_t;
   logic [31:0] mem [logic [31:0]];
   resp_t exp_q [2][$];
   int    delivered [2];
   int    mrdy_mode, rrdy_mode [2], val_prob, max_delay;
   int    cyc;
   int    win_log [$], fire_cyc [$], pop_cyc [$];
   resp_t r0_log [$];
   int    r1_seen;
   logic [7:0] last_opq;
   bit    last_mval, last_r0rdy;

   task automatic chk1(input string name, input bit act, input bit exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b want %0b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chki(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chkm(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_req(input int p, input bit wr, input logic [31:0] addr, input logic [31:0] data);
      req_t r;
      logic [31:0] s;
      s      = seq[p];
      r.typ  = wr ? 3'd1 : 3'd0;
      r.opq  = {p[0], s[6:0]};
      r.addr = addr;
      r.len  = 2'd0;
      r.data = wr ? data : 32'd0;
      seq[p]++;
      src_q[p].push_back(r);
   endtask

   // Bench memory: writes store, reads return stored data (0 if never written).
   function automatic resp_t mem_access(input req_t r);
      resp_t s;
      s.typ  = r.typ;
      s.opq  = r.opq;
      s.test = 2'd0;
      s.len  = r.len;
      s.data = 32'd0;
      if (r.typ == 3'd1) mem[r.addr] = r.data;
      else if (mem.exists(r.addr)) s.data = mem[r.addr];
      return s;
   endfunction

   function automatic bit pick(input int mode);
      return (mode == 2) ? ($urandom_range(3) != 0) : (mode == 1);
   endfunction

   // One clock: drive, predict+compare, then advance model and bench state.
   task automatic cycle();
      bit v [2];
      req_t m [2];
      bit g, full, empty, e_mval, e_mrr, fired;
      int head, t;
      resp_t got, rs;
      @(posedge clk); #1;
      cyc++;
      for (int p = 0; p < 2; p++) begin
         if (src_q[p].size() == 0) v[p] = 1'b0;
         else if (pres[p])         v[p] = 1'b1;
         else                      v[p] = ($urandom_range(99) < val_prob);
         m[p] = (src_q[p].size() != 0) ? src_q[p][0] : '0;
      end
      req0_val = v[0]; req0_msg = m[0];
      req1_val = v[1]; req1_msg = m[1];
      memreq_rdy = pick(mrdy_mode);
      resp0_rdy  = pick(rrdy_mode[0]);
      resp1_rdy  = pick(rrdy_mode[1]);
      memresp_val = (mem_q.size() != 0) && (mem_t[0] <= cyc);
      memresp_msg = (mem_q.size() != 0) ? mem_q[0] : '0;
      #3;
      full  = (mdl_q.size() == DEPTH);
      empty = (mdl_q.size() == 0);
      if (held >= 0)           g = held[0];
      else if (v[0] && v[1])   g = FIXED ? 1'b0 : rr;
      else                     g = v[1];
      e_mval = (v[0] || v[1]) && !full;
      head   = empty ? 0 : mdl_q[0];
      e_mrr  = !empty && ((head == 1) ? resp1_rdy : resp0_rdy);
      chk1("memreq_val", memreq_val, e_mval);
      chk1("req0_rdy", req0_rdy, !g && memreq_rdy && !full);
      chk1("req1_rdy", req1_rdy, g && memreq_rdy && !full);
      chk1("resp0_val", resp0_val, memresp_val && !empty && head == 0);
      chk1("resp1_val", resp1_val, memresp_val && !empty && head == 1);
      chk1("memresp_rdy", memresp_rdy, e_mrr);
      if (e_mval) chkm("memreq_msg", 128'(memreq_msg), 128'(m[g]));
      // Observed DUT events for the directed literal checks.
      if (memreq_val && memreq_rdy) begin
         win_log.push_back(int'(memreq_msg.opq[7]));
         fire_cyc.push_back(cyc);
      end
      if (memresp_val && memresp_rdy) pop_cyc.push_back(cyc);
      if (resp0_val && resp0_rdy) r0_log.push_back(resp0_msg);
      if (resp1_val) r1_seen++;
      last_opq   = memreq_msg.opq;
      last_mval  = memreq_val;
      last_r0rdy = req0_rdy;
      // Model advance: response pop first, then request push.
      if (memresp_val && e_mrr) begin
         got = (head == 1) ? resp1_msg : resp0_msg;
         chkm("resp_msg", 128'(got), 128'(exp_q[head][0]));
         void'(exp_q[head].pop_front());
         delivered[head]++;
         void'(mdl_q.pop_front());
         void'(mem_q.pop_front());
         void'(mem_t.pop_front());
      end
      fired = e_mval && memreq_rdy;
      if (fired) begin
         mdl_q.push_back(int'(g));
         rr   = ~g;
         held = -1;
         rs   = mem_access(m[g]);
         t    = cyc + 1 + int'($urandom_range(max_delay));
         if (t < last_t) t = last_t;
         last_t = t;
         mem_q.push_back(rs);
         mem_t.push_back(t);
         exp_q[g].push_back(rs);
         void'(src_q[g].pop_front());
      end else if (e_mval) begin
         held = int'(g);
      end
      for (int p = 0; p < 2; p++)
         pres[p] = v[p] && !(fired && int'(g) == p);
   endtask

   task automatic clear_logs();
      win_log.delete(); fire_cyc.delete(); pop_cyc.delete(); r0_log.delete();
      r1_seen = 0;
   endtask

   // Reset block and bench memory together; all outputs must read 0 meanwhile.
   task automatic do_reset();
      @(posedge clk); #1;
      req0_val = 0; req1_val = 0; req0_msg = '0; req1_msg = '0;
      memreq_rdy = 0; memresp_val = 0; memresp_msg = '0; resp0_rdy = 0; resp1_rdy = 0;
      reset = 1'b1;
      #3;
      chk1("rst_memreq_val", memreq_val, 1'b0);
      chk1("rst_req0_rdy", req0_rdy, 1'b0);
      chk1("rst_req1_rdy", req1_rdy, 1'b0);
      chk1("rst_resp0_val", resp0_val, 1'b0);
      chk1("rst_resp1_val", resp1_val, 1'b0);
      chk1("rst_memresp_rdy", memresp_rdy, 1'b0);
      for (int p = 0; p < 2; p++) begin
         src_q[p].delete(); exp_q[p].delete();
         pres[p] = 0; seq[p] = 0; delivered[p] = 0;
      end
      mdl_q.delete(); mem_q.delete(); mem_t.delete(); mem.delete();
      held = -1; rr = 1'b0; last_t = 0;
      clear_logs();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic run_idle(input string name, input int bound);
      int n = 0;
      while ((src_q[0].size() != 0 || src_q[1].size() != 0 || mdl_q.size() != 0) && n < bound) begin
         cycle();
         n++;
      end
      chki({name, "_drain_left"}, src_q[0].size() + src_q[1].size() + mdl_q.size(), 0);
   endtask

   int exp_rr [8]  = '{0, 1, 0, 1, 0, 1, 0, 1};
   int exp_fix [8] = '{0, 0, 0, 0, 1, 1, 1, 1};

   initial begin
      cyc = 0; held = -1;
      mrdy_mode = 1; rrdy_mode[0] = 1; rrdy_mode[1] = 1; val_prob = 100; max_delay = 0;
      do_reset();

      // Port 0 alone: write then read back.
      push_req(0, 1'b1, 32'h1000, 32'hdeadbeef);
      push_req(0, 1'b0, 32'h1000, 32'h0);
      run_idle("t1", 50);
      chki("t1_resp0_count", r0_log.size(), 2);
      if (r0_log.size() == 2) begin
         chki("t1_wr_ack_type", int'(r0_log[0].typ), 1);
         chkm("t1_rd_data", 128'(r0_log[1].data), 128'(32'hdeadbeef));
      end
      chki("t1_resp1_seen", r1_seen, 0);

      // Both valid every cycle: grant order.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_req(0, 1'b1, 32'h2000 + 32'(4 * i), 32'(i));
         push_req(1, 1'b1, 32'h3000 + 32'(4 * i), 32'(i));
      end
      run_idle("t2", 100);
      chki("t2_grants", win_log.size(), 8);
      for (int i = 0; i < 8 && i < win_log.size(); i++)
         chki("t2_grant_order", win_log[i], FIXED ? exp_fix[i] : exp_rr[i]);

      // Stalled grant stays on port 0 although port 1 wins ties (prio=1).
      do_reset();
      push_req(0, 1'b1, 32'h10, 32'h1);
      run_idle("t3a", 20);
      clear_logs();
      mrdy_mode = 0;
      push_req(0, 1'b0, 32'h10, 32'h0);
      cycle();
      chkm("t3_hold_c1", 128'(last_opq), 128'(8'h01));
      push_req(1, 1'b0, 32'h10, 32'h0);
      cycle();
      chkm("t3_hold_c2", 128'(last_opq), 128'(8'h01));
      cycle();
      chkm("t3_hold_c3", 128'(last_opq), 128'(8'h01));
      mrdy_mode = 1;
      run_idle("t3b", 20);
      chki("t3_fires", win_log.size(), 2);
      if (win_log.size() == 2) begin
         chki("t3_first", win_log[0], 0);
         chki("t3_second", win_log[1], 1);
      end

      // FIFO full with responses stalled.
      do_reset();
      rrdy_mode[0] = 0; rrdy_mode[1] = 0;
      for (int i = 0; i < 5; i++) push_req(0, 1'b0, 32'h40, 32'h0);
      repeat (8) cycle();
      chki("t4_fires_at_full", fire_cyc.size(), 4);
      chk1("t4_full_memreq_val", last_mval, 1'b0);
      chk1("t4_full_req0_rdy", last_r0rdy, 1'b0);
      rrdy_mode[0] = 1;
      run_idle("t4", 40);
      chki("t4_fires_total", fire_cyc.size(), 5);
      if (fire_cyc.size() == 5 && pop_cyc.size() != 0)
         chki("t4_fifth_after_pop", fire_cyc[4] - pop_cyc[0], 1);

      // Reset with three requests in flight, then fresh traffic.
      do_reset();
      rrdy_mode[0] = 0; rrdy_mode[1] = 0;
      for (int i = 0; i < 3; i++) push_req(1, 1'b0, 32'h80, 32'h0);
      repeat (4) cycle();
      chki("t6_inflight", fire_cyc.size(), 3);
      do_reset();
      rrdy_mode[0] = 1; rrdy_mode[1] = 1;
      push_req(0, 1'b0, 32'h80, 32'h0);
      push_req(1, 1'b0, 32'h80, 32'h0);
      run_idle("t6", 40);
      chki("t6_grants", win_log.size(), 2);
      if (win_log.size() == 2) begin
         chki("t6_first_is_p0", win_log[0], 0);
         chki("t6_second_is_p1", win_log[1], 1);
      end

      // Random interleaved traffic with memory latency and response stalls.
      delivered[0] = 0; delivered[1] = 0;
      val_prob = 60; mrdy_mode = 2; rrdy_mode[0] = 2; rrdy_mode[1] = 2; max_delay = 10;
      for (int i = 0; i < 40; i++)
         for (int p = 0; p < 2; p++)
            push_req(p, ($urandom_range(1) == 1), 32'h1000 + 32'(4 * $urandom_range(3)), $urandom);
      run_idle("t5", 4000);
      chki("t5_delivered_p0", delivered[0], 40);
      chki("t5_delivered_p1", delivered[1], 40);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

endmodule
